// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive core and the peripheral block that
// drives the serial pin and acknowledges received bytes.
interface uart_rx_core_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx,
    output rx_ack,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rx,
    input  rx_ack,
    output rx_data,
    output rx_done,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit and holds the last byte
// with sticky done / framing-error / overrun flags cleared by rx_ack.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input logic           clk,
  input logic           reset,
  uart_rx_core_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]      sync_vld_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  // rx_prev_q only reports a high once the synchroniser holds a real sample, so
  // a line already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= 2'b00;
      rx_prev_q  <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rx;
      rx_s_q     <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      rx_prev_q  <= sync_vld_q[1] & rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = rx_done_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    busy_d      = (state_q != StIdle);

    // Ack clears first so that a completion in the same cycle overrides it.
    if (bus.rx_ack) begin
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          state_d   = StData;
          cnt_d     = FullLoad;
          bit_idx_d = 3'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FullLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
          if (rx_s_q) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
            if (rx_done_q && !bus.rx_ack) begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end for the peripheral-mapped UART at 0x4000_0018..0x4000_0020. Synchronises the asynchronous `rx` pin, detects 8N1 frames at a fixed baud rate and presents each received byte with a sticky done flag. The flag is consumed by the data-memory/peripheral block, which mirrors `rx_data` into the receive-data word and `rx_done` into the receive-done word, and returns `rx_ack` when software clears receive-done. It also flags framing errors and overruns.

## Interface

- `CLKS_PER_BIT`, 10417, clk cycles per bit (100 MHz / 9600 baud); legal range ≥ 4.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock, no other reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_ack`  in  1  one-cycle pulse; clears `rx_done`, `frame_err` and `overrun`.
- `rx_data`  out  8  last good byte, LSB received first; reset 8'h00.
- `rx_done`  out  1  sticky; a byte is in `rx_data`; reset 0.
- `frame_err`  out  1  sticky; a stop bit was sampled low; reset 0.
- `overrun`  out  1  sticky; a byte completed while `rx_done` was already 1; reset 0.
- `busy`  out  1  high in any state other than IDLE; reset 0.

## Operation

- **Synchroniser:** two flops bring `rx` into the clock domain as `rx_s`. Both flops reset to 1.
- **Bit-time counter:** width $clog2(CLKS_PER_BIT). Reloaded on every state entry. Also holds a 3-bit bit index and an 8-bit shift register.
- **State machine** (IDLE, START, DATA, STOP):
  - IDLE: a high-to-low transition on `rx_s` goes to START. A line held low out of reset is not a start; a falling edge is required.
  - START: wait CLKS_PER_BIT/2 (integer division) cycles to reach mid start bit, then sample `rx_s`.
    - Sample 0: go to DATA with bit index 0.
    - Sample 1: glitch; return to IDLE. No flag changes.
  - DATA: wait CLKS_PER_BIT cycles, then shift `rx_s` into the MSB of the shift register (shift right). After the 8th sample, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, sample `rx_s`, then return to IDLE in all cases.
    - Sample 1: load `rx_data` from the shift register and set `rx_done`. If `rx_done` was already 1 and `rx_ack` is not asserted that cycle, also set `overrun`.
    - Sample 0: set `frame_err`. `rx_data` and `rx_done` are unchanged.
- **Flag rules:**
  - `rx_ack` alone clears all three sticky flags.
  - When `rx_ack` and a frame completion occur in the same cycle, completion wins. `rx_done` stays 1 and `overrun` stays 0.
  - A good frame with a simultaneous `rx_ack` also clears any prior `frame_err`.
  - `rx_ack` is ignored for state; it never aborts a frame in progress.
- **Overrun data policy:** on overrun the new byte overwrites `rx_data`.
- **Asynchronous reset mid-frame:** the FSM returns to IDLE, all outputs take their reset values and the partial byte is discarded. After reset deasserts, the next falling edge starts a fresh frame.

## Timing

- The falling edge on `rx` is seen in IDLE 2–3 cycles later (synchroniser plus edge detect).
- Start-bit sample occurs CLKS_PER_BIT/2 cycles after entering START. Data bit n is sampled (n+1)·CLKS_PER_BIT cycles after that point, and the stop bit 9·CLKS_PER_BIT cycles after it.
- `rx_done` and `rx_data` update together on the clock edge after the stop sample. They are registered with no combinational path from `rx`.
- The FSM is in IDLE about half a bit before the nominal end of the stop bit, so back-to-back frames with no idle gap are received without loss.
- `busy` rises the cycle after START is entered and falls the cycle after STOP or glitch exit.
- Tolerates baud mismatch up to ±4 % (mid-bit sampling); beyond that, behaviour is undefined.

## Test plan

- **Single byte:** CLKS_PER_BIT=16, drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> `rx_data`=8'hA5 and `rx_done`=1 within 3 cycles after the stop-bit midpoint. `frame_err`=0, `overrun`=0. Then `rx_ack` -> `rx_done`=0 next cycle.
- **Glitch:** `rx` low for 4 cycles (< CLKS_PER_BIT/2=8), then high -> FSM back in IDLE, `busy` falls. No flag changes; `rx_data` keeps its previous value.
- **Framing error:** frame 0x3C with stop bit 0 -> `frame_err`=1, `rx_done` unchanged, `rx_data` unchanged. Then `rx_ack` -> `frame_err`=0.
- **Back-to-back and overrun:** frames 0x11 and 0x22 with no idle gap and no ack -> `rx_data`=8'h22, `rx_done`=1, `overrun`=1. Repeat with `rx_ack` pulsed in the exact cycle the second frame completes -> `rx_done`=1, `overrun`=0.
- **Reset mid-frame:** assert `reset`=0 during data bit 4 of 0xFF -> all outputs go to 0 immediately, asynchronously. Release reset, send 0x5A -> `rx_data`=8'h5A, `rx_done`=1, with no residue from the aborted frame.
- **Line low at reset release:** hold `rx`=0 through reset release, raise it after 40 cycles, then send 0x81 -> no spurious frame; only 0x81 is received.
